// File: rtl/parking_request_queue.sv
// parking_request_queue: validates gate/sensor request pulses and queues them for the parking controller.
// Ports:
//   clock, reset        - system clock; asynchronous active-high reset.
//   license_plate[15:0] - four BCD digits, [15:12] most significant.
//   in_mode, out_mode   - one-cycle entry / exit request for license_plate.
//   leakage             - one-cycle leakage event on leakage_floor[2:0] (1..7).
//   todo_pop            - controller retires the presented request.
//   todo_*              - oldest pending request (all zero when todo_exists=0).
//   pending             - number of queued requests, including the presented one.
//   reject              - one-cycle pulse after a malformed request was discarded.
//   overflow            - sticky: a valid request was dropped because the queue was full.
// Optional macro PRQ_LEAK_PRIORITY_EN: leaks go to a one-entry register presented ahead of the FIFO.
module parking_request_queue #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [15:0]      license_plate,
    input  logic             in_mode,
    input  logic             out_mode,
    input  logic             leakage,
    input  logic [2:0]       leakage_floor,
    input  logic             todo_pop,
    output logic             todo_exists,
    output logic             todo_in,
    output logic             todo_out,
    output logic             todo_leak_move,
    output logic [15:0]      todo_license_plate,
    output logic [2:0]       todo_floor,
    output logic [CNT_W-1:0] pending,
    output logic             reject,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);

    // Entry: {kind[1:0] (01 in, 10 out, 11 leak), plate[15:0], floor[2:0]}
    logic [20:0]      mem [DEPTH];
    logic [AW-1:0]    wptr, rptr, wptr_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   free, need;
    logic [20:0]      head, plate_entry, leak_entry;
    logic             plate_req, plate_valid, plate_bad, leak_valid, leak_bad;
    logic             leak_push, plate_push, fifo_pop, leak_drop, drop;
`ifdef PRQ_LEAK_PRIORITY_EN
    logic             lreg_valid, lreg_pop;
    logic [2:0]       lreg_floor;
`endif

    always_comb begin
        plate_req   = in_mode | out_mode;
        plate_valid = plate_req && !(in_mode && out_mode) && license_plate != 16'd0 &&
                      license_plate[15:12] <= 4'd9 && license_plate[11:8] <= 4'd9 &&
                      license_plate[7:4] <= 4'd9 && license_plate[3:0] <= 4'd9;
        plate_bad   = plate_req && !plate_valid;
        leak_valid  = leakage && leakage_floor != 3'd0;
        leak_bad    = leakage && leakage_floor == 3'd0;
        plate_entry = {(in_mode ? 2'b01 : 2'b10), license_plate, 3'd0};
        leak_entry  = {2'b11, 16'd0, leakage_floor};
`ifdef PRQ_LEAK_PRIORITY_EN
        // The leak register is retired before the FIFO head.
        lreg_pop    = todo_pop && lreg_valid;
        fifo_pop    = todo_pop && !lreg_valid && count != '0;
`else
        fifo_pop    = todo_pop && count != '0;
`endif
        free        = (CNT_W+1)'(DEPTH) - {1'b0, count} + {{CNT_W{1'b0}}, fifo_pop};
`ifdef PRQ_LEAK_PRIORITY_EN
        leak_push   = 1'b0;
        // Overwriting an occupied register loses information only if the floor changes.
        leak_drop   = leak_valid && lreg_valid && !lreg_pop && leakage_floor != lreg_floor;
`else
        // Leak is pushed first, so it wins the last free slot.
        leak_push   = leak_valid && free != '0;
        leak_drop   = leak_valid && !leak_push;
`endif
        need        = leak_push ? (CNT_W+1)'(2) : (CNT_W+1)'(1);
        plate_push  = plate_valid && free >= need;
        drop        = leak_drop || (plate_valid && !plate_push);
        wptr_next   = wptr + AW'(1);
    end

    always_ff @(posedge clock) begin
        if (leak_push)
            mem[wptr] <= leak_entry;
        if (plate_push)
            mem[leak_push ? wptr_next : wptr] <= plate_entry;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            reject   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wptr     <= wptr + AW'(leak_push) + AW'(plate_push);
            rptr     <= rptr + AW'(fifo_pop);
            count    <= count + CNT_W'(leak_push) + CNT_W'(plate_push) - CNT_W'(fifo_pop);
            reject   <= plate_bad | leak_bad;
            overflow <= overflow | drop;
        end
    end

`ifdef PRQ_LEAK_PRIORITY_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lreg_valid <= 1'b0;
            lreg_floor <= 3'd0;
        end else if (leak_valid) begin
            lreg_valid <= 1'b1;
            lreg_floor <= leakage_floor;
        end else if (lreg_pop) begin
            lreg_valid <= 1'b0;
        end
    end

    assign head        = lreg_valid ? {2'b11, 16'd0, lreg_floor} : mem[rptr];
    assign todo_exists = lreg_valid || count != '0;
    assign pending     = count + CNT_W'(lreg_valid);
`else
    assign head        = mem[rptr];
    assign todo_exists = count != '0;
    assign pending     = count;
`endif

    // Head fields are gated so stale storage never leaks onto an idle interface.
    assign todo_in            = todo_exists && head[20:19] == 2'b01;
    assign todo_out           = todo_exists && head[20:19] == 2'b10;
    assign todo_leak_move     = todo_exists && head[20:19] == 2'b11;
    assign todo_license_plate = todo_exists ? head[18:3] : 16'd0;
    assign todo_floor         = todo_exists ? head[2:0] : 3'd0;
endmodule

// File: tb/tb_parking_request_queue.sv
// tb_parking_request_queue: directed self-checking bench for parking_request_queue.
module tb_parking_request_queue;
    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] license_plate;
    logic        in_mode, out_mode, leakage, todo_pop;
    logic [2:0]  leakage_floor;
    logic        todo_exists, todo_in, todo_out, todo_leak_move, reject, overflow;
    logic [15:0] todo_license_plate;
    logic [2:0]  todo_floor;
    logic [3:0]  pending;
    int          checks = 0;
    int          errors = 0;

    parking_request_queue dut (
        .clock(clock), .reset(reset), .license_plate(license_plate),
        .in_mode(in_mode), .out_mode(out_mode), .leakage(leakage),
        .leakage_floor(leakage_floor), .todo_pop(todo_pop),
        .todo_exists(todo_exists), .todo_in(todo_in), .todo_out(todo_out),
        .todo_leak_move(todo_leak_move), .todo_license_plate(todo_license_plate),
        .todo_floor(todo_floor), .pending(pending), .reject(reject), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Apply one cycle of inputs, then return them to idle one step past the edge.
    task automatic drive(input logic i, input logic o, input logic l, input logic [15:0] p,
                         input logic [2:0] f, input logic pop);
        in_mode = i; out_mode = o; leakage = l; license_plate = p; leakage_floor = f; todo_pop = pop;
        tick();
        in_mode = 0; out_mode = 0; leakage = 0; license_plate = 0; leakage_floor = 0; todo_pop = 0;
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, "_exists"}, todo_exists, 0);
        chk({tag, "_in"}, todo_in, 0);
        chk({tag, "_out"}, todo_out, 0);
        chk({tag, "_leak"}, todo_leak_move, 0);
        chk({tag, "_plate"}, todo_license_plate, 0);
        chk({tag, "_floor"}, todo_floor, 0);
        chk({tag, "_pending"}, pending, 0);
    endtask

    task automatic first_test(input string tag);
        drive(1, 0, 0, 16'h9423, 0, 0);
        chk({tag, "_exists"}, todo_exists, 1);
        chk({tag, "_in"}, todo_in, 1);
        chk({tag, "_plate"}, todo_license_plate, 16'h9423);
        chk({tag, "_pending"}, pending, 1);
        chk({tag, "_reject"}, reject, 0);
        drive(0, 0, 0, 0, 0, 1);
        idle_outputs({tag, "_popped"});
    endtask

    function automatic logic [15:0] bcd(int k);
        return {8'h10, 4'(k / 10), 4'(k % 10)};
    endfunction

    initial begin
        reset = 1; in_mode = 0; out_mode = 0; leakage = 0; license_plate = 0; leakage_floor = 0; todo_pop = 0;
        repeat (2) @(posedge clock);
        #1 reset = 0;
        idle_outputs("rst");
        chk("rst_reject", reject, 0);
        chk("rst_overflow", overflow, 0);

        first_test("t1");

        // Simultaneous exit and leak: leak entry first.
        drive(0, 1, 1, 16'h8754, 3'd2, 0);
        chk("t2_pending", pending, 2);
        chk("t2_leak", todo_leak_move, 1);
        chk("t2_floor", todo_floor, 2);
        chk("t2_leak_plate", todo_license_plate, 0);
        drive(0, 0, 0, 0, 0, 1);
        chk("t2_out", todo_out, 1);
        chk("t2_plate", todo_license_plate, 16'h8754);
        chk("t2_floor0", todo_floor, 0);
        chk("t2_pending1", pending, 1);
        drive(0, 0, 0, 0, 0, 1);
        chk("t2_empty", todo_exists, 0);

        // Malformed requests.
        drive(1, 0, 0, 16'h5A55, 0, 0);
        chk("bad_digit_rej", reject, 1);
        chk("bad_digit_pend", pending, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("rej_clears", reject, 0);
        drive(1, 1, 0, 16'h1234, 0, 0);
        chk("both_rej", reject, 1);
        chk("both_pend", pending, 0);
        drive(0, 0, 1, 0, 3'd0, 0);
        chk("floor0_rej", reject, 1);
        chk("floor0_pend", pending, 0);
        drive(1, 0, 0, 16'h0000, 0, 0);
        chk("zero_plate_rej", reject, 1);
        chk("zero_plate_pend", pending, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("rej_clears2", reject, 0);
        chk("no_ovf_yet", overflow, 0);

        // Fill to DEPTH, then one more.
        for (int k = 0; k < 8; k++) begin
            drive(1, 0, 0, 16'h2000 + 16'(k), 0, 0);
            chk($sformatf("fill_pend%0d", k), pending, k + 1);
        end
        chk("fill_ovf0", overflow, 0);
        drive(1, 0, 0, 16'h3000, 0, 0);
        chk("full_ovf", overflow, 1);
        chk("full_pend", pending, 8);
        chk("full_head", todo_license_plate, 16'h2000);
        drive(1, 0, 0, 16'h3001, 0, 1);
        chk("pp_pend", pending, 8);
        chk("pp_head", todo_license_plate, 16'h2001);
        for (int k = 1; k < 8; k++) begin
            chk($sformatf("drain_head%0d", k), todo_license_plate, 16'h2000 + 16'(k));
            drive(0, 0, 0, 0, 0, 1);
        end
        chk("drain_last", todo_license_plate, 16'h3001);
        chk("drain_out_in", todo_in, 1);
        drive(0, 0, 0, 0, 0, 1);
        chk("drain_empty", pending, 0);
        chk("ovf_sticky", overflow, 1);
        drive(0, 0, 0, 0, 0, 1);
        chk("pop_empty_ignored", pending, 0);

        // Wrap-around with simultaneous push/pop.
        drive(1, 0, 0, bcd(0), 0, 0);
        drive(1, 0, 0, bcd(1), 0, 0);
        for (int k = 2; k < 20; k++) begin
            drive(1, 0, 0, bcd(k), 0, 1);
            chk($sformatf("wrap_head%0d", k), todo_license_plate, bcd(k - 1));
            chk($sformatf("wrap_pend%0d", k), pending, 2);
        end
        drive(0, 0, 0, 0, 0, 1);
        chk("wrap_last", todo_license_plate, 16'h1019);
        drive(0, 0, 0, 0, 0, 1);
        chk("wrap_empty", todo_exists, 0);

        // Asynchronous reset mid-operation.
        for (int k = 0; k < 5; k++)
            drive(1, 0, 0, 16'h4000 + 16'(k), 0, 0);
        chk("pre_rst_pend", pending, 5);
        #3 reset = 1;
        #1;
        idle_outputs("async_rst");
        chk("async_rst_ovf", overflow, 0);
        chk("async_rst_rej", reject, 0);
        @(posedge clock);
        #1 reset = 0;
        first_test("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/parking_request_queue.md
Name: parking_request_queue

Overview:
- Front-end stage directly upstream of the parking_lot_top elevator/slot controller.
- Captures one-cycle request pulses (in_mode, out_mode, leakage) from the gate and sensor inputs and validates them.
- Buffers them in a FIFO and presents the oldest pending request on the todo_* interface.
- The controller retires each request with a one-cycle todo_pop once its target_floor/target_place work completes.

Parameters:
- DEPTH, 8, number of queued requests; power of two, minimum 4.
- CNT_W, $clog2(DEPTH+1), width of the pending count.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- license_plate  in  16  four BCD digits, [15:12] is the most significant.
- in_mode  in  1  one-cycle entry request for license_plate.
- out_mode  in  1  one-cycle exit request for license_plate.
- leakage  in  1  one-cycle leakage event.
- leakage_floor  in  3  floor of the leakage event; valid range 1..7.
- todo_pop  in  1  controller retires the presented request.
- todo_exists  out  1  a request is presented.
- todo_in  out  1  presented request is an entry.
- todo_out  out  1  presented request is an exit.
- todo_leak_move  out  1  presented request is a leakage evacuation.
- todo_license_plate  out  16  plate of the presented request; 0 for a leakage request.
- todo_floor  out  3  leakage floor of the presented request; 0 for entry/exit.
- pending  out  CNT_W  number of queued requests, including the presented one.
- reject  out  1  one-cycle pulse: an input request was malformed and discarded.
- overflow  out  1  sticky: a valid request was dropped because the queue was full.

Behaviour:
- Reset: every output is 0, the FIFO is empty, read and write pointers are 0.
- Entry layout: {kind[1:0] (01 in, 10 out, 11 leak), plate[15:0], floor[2:0]}.
- Validation, per rising edge:
  - in_mode or out_mode alone is valid only if every plate digit is ≤9 and the plate is nonzero.
  - in_mode and out_mode together is always malformed.
  - leakage is valid only if leakage_floor is nonzero.
  - Any malformed request is dropped and reject=1 for the next cycle.
- Simultaneous leakage with in/out: up to two pushes in one edge. The leak entry is written first, then the plate entry.
- Capacity: free = DEPTH − pending + todo_pop, where todo_pop counts only while todo_exists=1.
  - A leak request needs 1 free slot; if a plate request is also valid, it needs a second slot.
  - Leak has precedence for the last slot.
  - Each dropped valid request sets overflow. overflow clears only on reset.
- Pop: todo_pop while todo_exists=0 is ignored. Push and pop in the same edge are both honoured.
  - pending = pending + pushes − pops, saturating to neither bound.
- Latency: a request sampled at edge N is visible on todo_* after edge N when the queue was empty.
- todo_* outputs are driven from the head entry via registers/storage, with no combinational path from the inputs.
- When todo_exists=0, todo_in, todo_out, todo_leak_move, todo_license_plate and todo_floor are all 0.
- Pointers wrap modulo DEPTH. full = (pending==DEPTH), empty = (pending==0).
- No deduplication: repeated plates are queued as separate entries. Duplicate checking belongs to the controller.

Optional Feature:
- Macro: PRQ_LEAK_PRIORITY_EN.
- Defined:
  - A dedicated one-entry leak register sits outside the FIFO. A pending leak is presented ahead of the FIFO head.
  - todo_pop retires the leak register first.
  - A second leak arriving while the register is occupied overwrites the floor, and sets overflow only if the floor differs.
  - pending counts the leak register.
- Undefined: leak requests enter the FIFO in arrival order exactly as described in Behaviour.

Test Plan:
- Reset, then in_mode with plate 9423 (16'h9423) → next cycle: todo_exists=1, todo_in=1, todo_license_plate=16'h9423, pending=1. todo_pop → all todo_* are 0, pending=0.
- out_mode with plate 8754 and leakage with leakage_floor=2 in the same cycle → pending=2; head is leak, todo_floor=2; after pop, todo_out=1 with 16'h8754. With PRQ_LEAK_PRIORITY_EN the order is the same.
- Malformed inputs, each → reject pulses once and pending stays unchanged:
  - in_mode with plate 16'h5A55;
  - in_mode and out_mode together;
  - leakage with floor 0.
- Fill with 8 entries (DEPTH=8), then a ninth in_mode → overflow=1, pending=8. Pop and push in the same cycle → pending stays 8 and the head advances.
- Wrap-around: push/pop 20 sequential plates 1000..1019 → dequeued in order, and pointers wrap correctly.
- Assert reset mid-operation with pending=5 → all outputs are 0 immediately, without waiting for a clock edge. A subsequent request behaves as in the first test.
